// File: rtl/branch_redirect_ctrl.sv
// Branch resolution and fetch redirect controller.
// Compares the execute-stage outcome against the fetch-time prediction. On a
// mismatch it pulses flush for one cycle and holds a redirect to fetch until
// it is accepted, squashing execute results meanwhile. Also owns the 2-bit
// saturating BHT that fetch reads and that this block trains on resolution.
module branch_redirect_ctrl #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned BHT_ENTRIES = 64,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic             ex_is_ctrl,
   input  logic             ex_is_cond,
   input  logic             ex_taken,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   input  logic [XLEN-1:0]  if_pc,
   output logic             if_pred_taken,
   output logic             flush,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   input  logic             redirect_ready,
   output logic             ex_squash,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

   typedef enum logic {IDLE, REDIRECT} state_t;

   state_t           state_q, state_d;
   logic             flush_q, flush_d;
   logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [1:0]       bht_d [BHT_ENTRIES];

   logic [XLEN-1:0]  pc_plus4;
   logic [XLEN-1:0]  actual_next;
   logic [XLEN-1:0]  pred_next;
   logic [IDX_W-1:0] ex_idx;
   logic [IDX_W-1:0] if_idx;
   logic             resolve;
   logic             mispredict;
   logic             train;
   logic             if_pc_unused;

   // Resolution datapath and BHT lookup
   always_comb begin
      pc_plus4      = ex_pc + XLEN'(4);
      actual_next   = ex_taken ? ex_target : pc_plus4;
      pred_next     = ex_pred_taken ? ex_pred_target : pc_plus4;
      resolve       = (state_q == IDLE) && ex_valid && ex_is_ctrl;
      mispredict    = resolve && (actual_next != pred_next);
      train         = (state_q == IDLE) && ex_valid && ex_is_cond;
      ex_idx        = ex_pc[IDX_W+1:2];
      if_idx        = if_pc[IDX_W+1:2];
      if_pred_taken = bht_q[if_idx][1];
      if_pc_unused  = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};
   end

   // Next-state, redirect capture, statistics and BHT training
   always_comb begin
      state_d       = state_q;
      flush_d       = mispredict;
      redirect_pc_d = redirect_pc_q;
      cnt_d         = cnt_q;
      bht_d         = bht_q;
      case (state_q)
         IDLE: begin
            if (mispredict) begin
               state_d       = REDIRECT;
               redirect_pc_d = actual_next;
               if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end
         end
         REDIRECT: begin
            if (redirect_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (train) begin
         if (ex_taken) begin
            if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
         end else begin
            if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
         end
      end
   end

   // State and table registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         flush_q       <= 1'b0;
         redirect_pc_q <= '0;
         cnt_q         <= '0;
         for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else begin
         state_q       <= state_d;
         flush_q       <= flush_d;
         redirect_pc_q <= redirect_pc_d;
         cnt_q         <= cnt_d;
         bht_q         <= bht_d;
      end
   end

   // Output mapping
   always_comb begin
      flush            = flush_q;
      redirect_valid   = (state_q == REDIRECT);
      ex_squash        = (state_q == REDIRECT);
      redirect_pc      = redirect_pc_q;
      mispredict_count = cnt_q;
   end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed testbench for branch_redirect_ctrl (CNT_W reduced to 4 so the
// statistics counter can be driven into saturation).
module tb_branch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_is_ctrl, ex_is_cond, ex_taken, ex_pred_taken;
   logic [63:0] ex_pc, ex_target, ex_pred_target, if_pc;
   logic        if_pred_taken, flush, redirect_valid, redirect_ready, ex_squash;
   logic [63:0] redirect_pc;
   logic [3:0]  mispredict_count;

   int n_cmp = 0;
   int n_err = 0;

   branch_redirect_ctrl #(.XLEN(64), .BHT_ENTRIES(64), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_is_ctrl(ex_is_ctrl), .ex_is_cond(ex_is_cond),
      .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .if_pc(if_pc), .if_pred_taken(if_pred_taken), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready), .ex_squash(ex_squash),
      .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ex(input logic v, input logic ctrl, input logic cond, input logic tk,
                         input logic [63:0] pc, input logic [63:0] tgt,
                         input logic pt, input logic [63:0] ptgt);
      ex_valid = v; ex_is_ctrl = ctrl; ex_is_cond = cond; ex_taken = tk;
      ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
   endtask

   task automatic chk_out(input string tag, input logic fl, input logic rv,
                          input logic [63:0] rpc, input logic sq, input logic [3:0] cnt);
      chk({tag, ".flush"}, 64'(flush), 64'(fl));
      chk({tag, ".rvalid"}, 64'(redirect_valid), 64'(rv));
      chk({tag, ".rpc"}, redirect_pc, rpc);
      chk({tag, ".squash"}, 64'(ex_squash), 64'(sq));
      chk({tag, ".count"}, 64'(mispredict_count), 64'(cnt));
   endtask

   initial begin
      logic [3:0] exp_cnt;
      reset = 1'b0; redirect_ready = 1'b0; if_pc = 64'h8000_0000;
      set_ex(0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0);
      tick(); tick();
      reset = 1'b1;

      // Reset state
      chk_out("reset", 0, 0, 64'h0, 0, 4'd0);
      chk("reset.bht0", 64'(if_pred_taken), 64'd0);
      if_pc = 64'h8000_00FC;
      #1 chk("reset.bht63", 64'(if_pred_taken), 64'd0);
      tick();
      chk_out("idle", 0, 0, 64'h0, 0, 4'd0);

      // Taken BEQ predicted not-taken: mispredict
      if_pc = 64'h8000_0010;
      set_ex(1, 1, 1, 1, 64'h8000_0010, 64'h8000_0100, 0, 64'h0);
      #1 chk("beq.bht_old", 64'(if_pred_taken), 64'd0);
      tick();
      chk_out("beq.n1", 1, 1, 64'h8000_0100, 1, 4'd1);
      chk("beq.bht_new", 64'(if_pred_taken), 64'd1);

      // Redirect held with ready low; wrong-path mispredicts must be ignored
      set_ex(1, 1, 1, 0, 64'h8000_0010, 64'h0, 1, 64'h123);
      tick();
      chk_out("hold1", 0, 1, 64'h8000_0100, 1, 4'd1);
      chk("hold1.bht", 64'(if_pred_taken), 64'd1);
      tick();
      chk_out("hold2", 0, 1, 64'h8000_0100, 1, 4'd1);
      redirect_ready = 1'b1;
      #1 chk_out("hs", 0, 1, 64'h8000_0100, 1, 4'd1);
      tick();
      set_ex(0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0);
      redirect_ready = 1'b0;
      chk_out("back_idle", 0, 0, 64'h8000_0100, 0, 4'd1);
      chk("hold.bht", 64'(if_pred_taken), 64'd1);

      // JALR at top of address space, predicted not-taken
      set_ex(1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1000, 0, 64'h0);
      tick();
      chk_out("jalr", 1, 1, 64'h1000, 1, 4'd2);
      set_ex(0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0);
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      chk_out("jalr.done", 0, 0, 64'h1000, 0, 4'd2);
      if_pc = 64'h0000_00FC;
      #1 chk("jalr.notrain", 64'(if_pred_taken), 64'd0);

      // Not-taken branch at same PC: fall-through wraps to 0
      set_ex(1, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 1, 64'h4);
      tick();
      chk_out("wrap", 1, 1, 64'h0, 1, 4'd3);
      set_ex(0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0);
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      // Correctly predicted version: predicted target 0 matches wrapped pc+4
      set_ex(1, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 1, 64'h0);
      tick();
      set_ex(0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0);
      chk_out("wrap.ok", 0, 0, 64'h0, 0, 4'd3);

      // Saturating BHT training on index 5, all correctly predicted
      if_pc = 64'h8000_0014;
      for (int i = 0; i < 4; i++) begin
         set_ex(1, 1, 1, 1, 64'h8000_0014, 64'h8000_0200, 1, 64'h8000_0200);
         tick();
         chk($sformatf("bne_t%0d.bht", i), 64'(if_pred_taken), 64'd1);
         chk($sformatf("bne_t%0d.flush", i), 64'(flush), 64'd0);
      end
      for (int i = 0; i < 4; i++) begin
         set_ex(1, 1, 1, 0, 64'h8000_0014, 64'h8000_0200, 0, 64'h0);
         tick();
         chk($sformatf("bne_n%0d.bht", i), 64'(if_pred_taken), (i == 0) ? 64'd1 : 64'd0);
         chk($sformatf("bne_n%0d.flush", i), 64'(flush), 64'd0);
      end
      set_ex(1, 1, 1, 1, 64'h8000_0014, 64'h8000_0200, 1, 64'h8000_0200);
      tick();
      chk("bne_up.bht", 64'(if_pred_taken), 64'd0);
      set_ex(1, 1, 1, 1, 64'h8000_0014, 64'h8000_0200, 1, 64'h8000_0200);
      tick();
      chk("bne_up2.bht", 64'(if_pred_taken), 64'd1);
      set_ex(0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0);
      chk_out("bht.done", 0, 0, 64'h0, 0, 4'd3);

      // Drive the statistics counter into saturation with JAL mispredicts
      exp_cnt = 4'd3;
      for (int i = 0; i < 14; i++) begin
         set_ex(1, 1, 0, 1, 64'h8000_0020, 64'h40 + 64'(i), 0, 64'h0);
         redirect_ready = 1'b1;
         tick();
         if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
         chk($sformatf("sat%0d.count", i), 64'(mispredict_count), 64'(exp_cnt));
         chk($sformatf("sat%0d.flush", i), 64'(flush), 64'd1);
         set_ex(0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0);
         tick();
      end
      redirect_ready = 1'b0;
      chk_out("sat.final", 0, 0, 64'h4D, 0, 4'hF);

      // Reset while a redirect is pending
      set_ex(1, 1, 0, 1, 64'h8000_0020, 64'h80, 0, 64'h0);
      tick();
      set_ex(0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0);
      chk_out("pre_rst", 1, 1, 64'h80, 1, 4'hF);
      reset = 1'b0;
      tick();
      chk_out("mid_rst", 0, 0, 64'h0, 0, 4'd0);
      if_pc = 64'h8000_0010;
      #1 chk("mid_rst.bht4", 64'(if_pred_taken), 64'd0);
      reset = 1'b1;
      tick();
      chk_out("post_rst", 0, 0, 64'h0, 0, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
